// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//
// SPI slave front end for a small RAM. All logic is on the rising edge of
// clk. While SS_n is low, one MOSI bit is taken per clk edge. The first edge
// leaves IDLE, the next edge samples the command bit (frame bit 9), and the
// remaining MEM_WIDTH+1 bits follow MSB first.
//
// A completed frame is presented on rx_data with a one-cycle rx_valid strobe.
// A read-address frame arms addr_flag. A following read-data frame then
// waits for the RAM's tx_valid, latches tx_data, and shifts it out on MISO,
// MSB first.
//
// Optional feature (macro SPI_SLAVE_FRAME_ERR_EN):
//   adds output frame_err. It pulses for one cycle after SS_n aborts a
//   partially received frame or a MISO shift that is still in progress.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   SS_n       in   slave select, active low
//   MOSI       in   serial data in, MSB first
//   MISO       out  serial read data out, MSB first, registered
//   rx_data    out  [MEM_WIDTH+1:0] assembled frame ([9:8] command)
//   rx_valid   out  one-cycle strobe, rx_data valid
//   tx_data    in   [MEM_WIDTH-1:0] read data from the RAM
//   tx_valid   in   strobe, tx_data valid
//   frame_err  out  abort indication (only with SPI_SLAVE_FRAME_ERR_EN)
// ---------------------------------------------------------------------------
module spi_slave #(
    parameter int MEM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SS_n,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [MEM_WIDTH+1:0]   rx_data,
    output logic                   rx_valid,
    input  logic [MEM_WIDTH-1:0]   tx_data,
    input  logic                   tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic                   frame_err
`endif
);

    localparam int FRAME_W = MEM_WIDTH + 2;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int TX_W    = $clog2(MEM_WIDTH + 1);

    // The counter holds the bits taken after the command bit. LAST_CNT means
    // "this edge samples bit 0". DONE_CNT means "the frame is complete and
    // any extra bits are ignored".
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_WIDTH);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(MEM_WIDTH + 1);
    localparam logic [TX_W-1:0]  TX_LAST  = TX_W'(MEM_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        CHK_CMD   = 3'b001,
        READ_ADD  = 3'b010,
        READ_DATA = 3'b011,
        WRITE     = 3'b100
    } state_t;

    state_t                 state_q,     state_d;
    logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [FRAME_W-2:0]     rx_shift_q,  rx_shift_d;
    logic [FRAME_W-1:0]     rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   addr_flag_q, addr_flag_d;
    logic [MEM_WIDTH-1:0]   tx_shift_q,  tx_shift_d;
    logic [TX_W-1:0]        tx_left_q,   tx_left_d;
    logic                   tx_busy_q,   tx_busy_d;
    logic                   tx_taken_q,  tx_taken_d;
    logic                   miso_q,      miso_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                   frame_err_q, frame_err_d;
`endif

    // Next-state and datapath logic.
    // rx_shift keeps the frame bits taken so far. When bit 0 arrives, it is
    // joined with MOSI to form rx_data. On the read side, tx_busy marks an
    // active MISO shift. tx_taken stops a second latch of tx_data within the
    // same frame.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        addr_flag_d = addr_flag_q;
        tx_shift_d  = tx_shift_q;
        tx_left_d   = tx_left_q;
        tx_busy_d   = tx_busy_q;
        tx_taken_d  = tx_taken_q;
        miso_d      = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                bit_cnt_d  = '0;
                tx_shift_d = '0;
                tx_left_d  = '0;
                tx_busy_d  = 1'b0;
                tx_taken_d = 1'b0;
                if (!SS_n) begin
                    state_d = CHK_CMD;
                end
            end

            CHK_CMD: begin
                if (SS_n) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    rx_shift_d = {rx_shift_q[FRAME_W-3:0], MOSI};
                    bit_cnt_d  = '0;
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (addr_flag_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
            end

            WRITE, READ_ADD, READ_DATA: begin
                if (bit_cnt_q == LAST_CNT) begin
                    // Bit 0 completes the frame even if SS_n rises on this
                    // same edge.
                    rx_data_d  = {rx_shift_q, MOSI};
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = DONE_CNT;
                    if (state_q == READ_ADD) begin
                        addr_flag_d = 1'b1;
                    end
                    if (SS_n) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end
                end else if (SS_n) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    tx_shift_d = '0;
                    tx_left_d  = '0;
                    tx_busy_d  = 1'b0;
                    tx_taken_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    frame_err_d = (bit_cnt_q != DONE_CNT) || tx_busy_q;
`endif
                end else if (bit_cnt_q != DONE_CNT) begin
                    rx_shift_d = {rx_shift_q[FRAME_W-3:0], MOSI};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                end else if (state_q == READ_DATA) begin
                    if (tx_busy_q) begin
                        if (tx_left_q == '0) begin
                            // The last bit has been shown. Disarm the read.
                            tx_busy_d   = 1'b0;
                            addr_flag_d = 1'b0;
                        end else begin
                            miso_d     = tx_shift_q[MEM_WIDTH-1];
                            tx_shift_d = tx_shift_q << 1;
                            tx_left_d  = tx_left_q - 1'b1;
                        end
                    end else if (tx_valid && !tx_taken_q) begin
                        // The MSB goes straight out. The shifter keeps the
                        // remaining bits.
                        miso_d     = tx_data[MEM_WIDTH-1];
                        tx_shift_d = tx_data << 1;
                        tx_left_d  = TX_LAST;
                        tx_busy_d  = 1'b1;
                        tx_taken_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset has priority over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            addr_flag_q <= 1'b0;
            tx_shift_q  <= '0;
            tx_left_q   <= '0;
            tx_busy_q   <= 1'b0;
            tx_taken_q  <= 1'b0;
            miso_q      <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            addr_flag_q <= addr_flag_d;
            tx_shift_q  <= tx_shift_d;
            tx_left_q   <= tx_left_d;
            tx_busy_q   <= tx_busy_d;
            tx_taken_q  <= tx_taken_d;
            miso_q      <= miso_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
//
// Self-checking bench for spi_slave. Directed scenarios are followed by a
// randomized run. A transaction-level model tracks the last good frame and
// whether a read address is armed. Expected values come from that model,
// not from the design.
// ---------------------------------------------------------------------------
module tb_spi_slave;

    localparam int W = 8;

    localparam logic [2:0] S_IDLE      = 3'b000;
    localparam logic [2:0] S_READ_ADD  = 3'b010;
    localparam logic [2:0] S_READ_DATA = 3'b011;
    localparam logic [2:0] S_WRITE     = 3'b100;

    logic           clk = 1'b0;
    logic           rst;
    logic           SS_n;
    logic           MOSI;
    logic           MISO;
    logic [W+1:0]   rx_data;
    logic           rx_valid;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic           frame_err;
`endif

    int errors = 0;
    int checks = 0;

    // Model: last completed frame and armed read address.
    logic [9:0] m_rx;
    logic       m_flag;

    int rvc, rvp, mo;
    logic [8:0] seq;

    spi_slave #(.MEM_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        tick(); tick();
        rst = 1'b0;
        m_rx = '0; m_flag = 1'b0;
    endtask

    // Select the slave; the edge moves the design out of IDLE.
    task automatic open_frame();
        SS_n = 1'b0;
        tick();
    endtask

    task automatic close_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    // Drive frame bits by index (0 = frame bit 9). Extra random bits follow.
    // The rx_valid strobes and MISO ones seen after each edge are recorded.
    task automatic drive_bits(input logic [9:0] f, input int first, input int nbits,
                              input int extra, input bit ss_on_last,
                              output int rv_cnt, output int rv_pos, output int miso_ones);
        rv_cnt = 0; rv_pos = -1; miso_ones = 0;
        for (int i = first; i < first + nbits + extra; i++) begin
            MOSI = (i < first + nbits) ? f[9-i] : 1'($urandom);
            if (ss_on_last && i == first + nbits + extra - 1) SS_n = 1'b1;
            tick();
            if (rx_valid === 1'b1) begin
                rv_cnt++;
                if (rv_pos < 0) rv_pos = i;
            end
            if (MISO !== 1'b0) miso_ones++;
        end
        MOSI = 1'b0;
    endtask

    // Pulse tx_valid after a delay and hold it for 'hold' cycles with fresh data.
    // Record MISO after the latch edge and the 8 edges that follow.
    task automatic serve_read(input logic [7:0] d, input int delay, input int hold,
                              output logic [8:0] s);
        tx_valid = 1'b0;
        repeat (delay) tick();
        tx_data = d; tx_valid = 1'b1;
        tick();
        s[8] = MISO;
        for (int k = 1; k <= 8; k++) begin
            tx_valid = (k < hold);
            tx_data  = 8'($urandom);
            tick();
            s[8-k] = MISO;
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        tick(); tick();
        checks++; if (MISO !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso got=%b exp=0", MISO); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 10'h000) begin errors++; $display("[TB] FAIL reset_rx_data got=%h exp=000", rx_data); end
        checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("[TB] FAIL reset_state got=%b exp=%b", dut.state_q, S_IDLE); end
        rst = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0;
        m_rx = '0; m_flag = 1'b0;
        tick();
    endtask

    task automatic test_write_frame();
        open_frame();
        drive_bits(10'b00_1010_0101, 0, 10, 2, 1'b0, rvc, rvp, mo);
        checks++; if (rx_data !== 10'h0A5) begin errors++; $display("[TB] FAIL write_rx_data got=%h exp=0a5", rx_data); end
        checks++; if (rvc !== 1) begin errors++; $display("[TB] FAIL write_rv_count got=%0d exp=1", rvc); end
        checks++; if (rvp !== 9) begin errors++; $display("[TB] FAIL write_rv_pos got=%0d exp=9", rvp); end
        checks++; if (mo !== 0) begin errors++; $display("[TB] FAIL write_miso got=%0d exp=0", mo); end
        close_frame();
        m_rx = 10'h0A5;
    endtask

    task automatic test_read_sequence();
        open_frame();
        drive_bits(10'b10_0000_0011, 0, 10, 1, 1'b0, rvc, rvp, mo);
        checks++; if (rx_data !== 10'h203) begin errors++; $display("[TB] FAIL rdaddr_rx_data got=%h exp=203", rx_data); end
        checks++; if (dut.addr_flag_q !== 1'b1) begin errors++; $display("[TB] FAIL rdaddr_flag got=%b exp=1", dut.addr_flag_q); end
        close_frame();
        open_frame();
        drive_bits(10'b11_0000_0000, 0, 10, 0, 1'b0, rvc, rvp, mo);
        checks++; if (rx_data !== 10'h300 || rvc !== 1) begin errors++; $display("[TB] FAIL rddata_rx got=%h/%0d exp=300/1", rx_data, rvc); end
        checks++; if (dut.state_q !== S_READ_DATA) begin errors++; $display("[TB] FAIL rddata_state got=%b exp=%b", dut.state_q, S_READ_DATA); end
        serve_read(8'hC3, 2, 1, seq);
        checks++; if (seq !== 9'b1100_0011_0) begin errors++; $display("[TB] FAIL rddata_miso got=%b exp=110000110", seq); end
        checks++; if (dut.addr_flag_q !== 1'b0) begin errors++; $display("[TB] FAIL rddata_flag_clear got=%b exp=0", dut.addr_flag_q); end
        close_frame();
        m_rx = 10'h300; m_flag = 1'b0;
    endtask

    task automatic test_read_no_addr();
        do_reset();
        open_frame();
        drive_bits(10'b11_0110_1001, 0, 1, 0, 1'b0, rvc, rvp, mo);
        checks++; if (dut.state_q !== S_READ_ADD) begin errors++; $display("[TB] FAIL noaddr_state got=%b exp=%b", dut.state_q, S_READ_ADD); end
        drive_bits(10'b11_0110_1001, 1, 9, 0, 1'b0, rvc, rvp, mo);
        serve_read(8'hFF, 1, 3, seq);
        checks++; if (seq !== 9'b0) begin errors++; $display("[TB] FAIL noaddr_miso got=%b exp=0", seq); end
        checks++; if (rx_data !== 10'h369) begin errors++; $display("[TB] FAIL noaddr_rx_data got=%h exp=369", rx_data); end
        close_frame();
        m_rx = 10'h369; m_flag = 1'b1;
    endtask

    task automatic test_abort();
        open_frame();
        drive_bits(10'b00_1111_0000, 0, 5, 0, 1'b0, rvc, rvp, mo);
        SS_n = 1'b1;
        tick();
        checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("[TB] FAIL abort_state got=%b exp=%b", dut.state_q, S_IDLE); end
        checks++; if (rx_valid !== 1'b0 || rvc !== 0) begin errors++; $display("[TB] FAIL abort_rx_valid got=%b/%0d exp=0/0", rx_valid, rvc); end
        checks++; if (rx_data !== m_rx) begin errors++; $display("[TB] FAIL abort_rx_data got=%h exp=%h", rx_data, m_rx); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL abort_frame_err got=%b exp=1", frame_err); end
        tick();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL abort_frame_err_pulse got=%b exp=0", frame_err); end
`endif
    endtask

    task automatic test_ss_on_last();
        open_frame();
        drive_bits(10'b01_0101_1010, 0, 10, 0, 1'b1, rvc, rvp, mo);
        checks++; if (rvc !== 1 || rvp !== 9) begin errors++; $display("[TB] FAIL sslast_rv got=%0d@%0d exp=1@9", rvc, rvp); end
        checks++; if (rx_data !== 10'h15A) begin errors++; $display("[TB] FAIL sslast_rx_data got=%h exp=15a", rx_data); end
        checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("[TB] FAIL sslast_state got=%b exp=%b", dut.state_q, S_IDLE); end
        m_rx = 10'h15A;
        tick();
    endtask

    task automatic test_reset_mid_shift();
        logic [2:0] head;
        do_reset();
        open_frame(); drive_bits(10'b10_0001_0000, 0, 10, 0, 1'b0, rvc, rvp, mo); close_frame();
        open_frame(); drive_bits(10'b11_0001_0000, 0, 10, 0, 1'b0, rvc, rvp, mo);
        tick();
        tx_data = 8'hC3; tx_valid = 1'b1;
        tick(); head[2] = MISO;
        tx_valid = 1'b0;
        tick(); head[1] = MISO;
        tick(); head[0] = MISO;
        tick();
        checks++; if (head !== 3'b110) begin errors++; $display("[TB] FAIL midshift_head got=%b exp=110", head); end
        rst = 1'b1;
        tick();
        checks++; if (MISO !== 1'b0 || dut.state_q !== S_IDLE) begin errors++; $display("[TB] FAIL midshift_reset got=%b/%b exp=0/%b", MISO, dut.state_q, S_IDLE); end
        rst = 1'b0; SS_n = 1'b1;
        m_rx = '0; m_flag = 1'b0;
        tick();
        open_frame();
        drive_bits(10'b11_0000_0001, 0, 1, 0, 1'b0, rvc, rvp, mo);
        checks++; if (dut.state_q !== S_READ_ADD) begin errors++; $display("[TB] FAIL midshift_next got=%b exp=%b", dut.state_q, S_READ_ADD); end
        drive_bits(10'b11_0000_0001, 1, 9, 0, 1'b0, rvc, rvp, mo);
        close_frame();
        m_rx = 10'h301; m_flag = 1'b1;
    endtask

    task automatic test_stray_tx_valid();
        int ones = 0;
        int moved = 0;
        SS_n = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        repeat (4) begin
            tick();
            if (MISO !== 1'b0) ones++;
            if (dut.state_q !== S_IDLE) moved++;
        end
        checks++; if (ones !== 0 || moved !== 0) begin errors++; $display("[TB] FAIL stray_idle got=%0d/%0d exp=0/0", ones, moved); end
        open_frame();
        drive_bits(10'b00_0011_1100, 0, 10, 2, 1'b0, rvc, rvp, mo);
        checks++; if (mo !== 0 || dut.state_q !== S_WRITE) begin errors++; $display("[TB] FAIL stray_write got=%0d/%b exp=0/%b", mo, dut.state_q, S_WRITE); end
        tx_valid = 1'b0;
        close_frame();
        m_rx = 10'h03C;
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [9:0] f;
            int kind;
            int nb;
            int exp_rv;
            f    = 10'($urandom);
            kind = $urandom_range(0, 2);
            open_frame();
            if (kind == 1) begin
                nb = $urandom_range(2, 8);
                drive_bits(f, 0, nb, 0, 1'b0, rvc, rvp, mo);
                SS_n = 1'b1;
                tick();
                if (rx_valid === 1'b1) rvc++;
                exp_rv = 0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL rand_frame_err iter=%0d got=%b exp=1", n, frame_err); end
`endif
            end else begin
                drive_bits(f, 0, 10, (kind == 2) ? $urandom_range(1, 4) : 0, 1'b0, rvc, rvp, mo);
                exp_rv = 1;
                m_rx = f;
                if (f[9] && m_flag) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    serve_read(d, $urandom_range(1, 3), $urandom_range(1, 3), seq);
                    checks++; if (seq !== {d, 1'b0}) begin errors++; $display("[TB] FAIL rand_miso iter=%0d got=%b exp=%b", n, seq, {d, 1'b0}); end
                    m_flag = 1'b0;
                end else if (f[9]) begin
                    m_flag = 1'b1;
                end
                close_frame();
                if (rx_valid === 1'b1) rvc++;
            end
            checks++; if (rvc !== exp_rv) begin errors++; $display("[TB] FAIL rand_rv iter=%0d got=%0d exp=%0d", n, rvc, exp_rv); end
            checks++; if (rx_data !== m_rx) begin errors++; $display("[TB] FAIL rand_rx_data iter=%0d got=%h exp=%h", n, rx_data, m_rx); end
            checks++; if (dut.addr_flag_q !== m_flag) begin errors++; $display("[TB] FAIL rand_flag iter=%0d got=%b exp=%b", n, dut.addr_flag_q, m_flag); end
        end
    endtask

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        test_reset();
        test_write_frame();
        test_read_sequence();
        test_abort();
        test_ss_on_last();
        test_read_no_addr();
        test_reset_mid_shift();
        test_stray_tx_valid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
